satd_hadamard_accum: RTL
========================

# satd_hadamard_accum

Downstream consumer of the SATD difference stage. Accepts one row of eight signed residuals per cycle (`diff_in_0..7`) for eight rows. Applies an 8-point Hadamard transform to each row on entry and stores the results in a transpose buffer. It then transforms the eight columns, one per cycle, accumulates the absolute values of all 64 coefficients, and presents the 8x8 SATD cost for one block.

## Interface
Parameters:
- `DIFF_W`, default 9: width of each signed residual input.
- Row-coefficient width is DIFF_W+3 (fixed). Column-coefficient width is DIFF_W+6 (fixed).
- `SUM_W`, default DIFF_W+11: width of the SATD output.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `clear`  in  1: synchronous abort; returns to IDLE and drops any partial block.
- `in_valid`  in  1: the current row on `diff_in_*` is valid.
- `in_ready`  out  1: block can accept a row.
- `diff_in_0` .. `diff_in_7`  in  DIFF_W each, signed: residual samples, column 0..7 of the current row.
- `satd_out`  out  SUM_W: SATD of the last completed block.
- `satd_valid`  out  1: one-cycle pulse; `satd_out` is new.
- `busy`  out  1: high in COL and DONE.

## Operation
- FSM states: IDLE, LOAD, COL, DONE.
  - IDLE, LOAD → `in_ready=1`.
  - COL, DONE → `in_ready=0`.
- Row acceptance: a row is accepted on an edge where `in_valid && in_ready`. `in_valid` while `in_ready=0` is ignored, not queued.
- Row transform:
  - The row passes combinationally through 3 butterfly stages (a+b / a−b), sign-extended to DIFF_W+3.
  - The result is written to buffer row `row_cnt` (3-bit).
  - `row_cnt` increments per accepted row.
  - First accepted row: IDLE→LOAD.
  - 8th accepted row (`row_cnt==7`): →COL, with `row_cnt` wrapping to 0 and `acc` cleared.
- COL: the column counter `col_cnt` runs 0..7. Each cycle:
  - Read buffer column `col_cnt`.
  - Apply the 3-stage Hadamard at width DIFF_W+6.
  - Take the absolute value of each of the 8 outputs.
  - Sum the 8 values with an adder tree and add the sum to `acc`.
  - After `col_cnt==7` is accumulated: →DONE.
- DONE (one cycle):
  - `satd_out` = final value; `satd_valid=1`.
  - Next state IDLE.
- `satd_out` holds its value until the next DONE.
- Arithmetic: all intermediate values are two's complement with no saturation. Widths are sized so overflow is impossible for any DIFF_W-bit inputs (max |coef| = 64·2^(DIFF_W−1)).
- `clear`:
  - Has priority over all transitions.
  - At the edge: state←IDLE, `row_cnt`←0, `col_cnt`←0, `acc`←0.
  - No `satd_valid` for the aborted block.
  - `satd_out` keeps its previous value.
- `clear` together with `in_valid` in the same cycle: the row is discarded.
- Coefficient ordering within the transform is irrelevant to the result (sum of absolute values).

## Timing
- Reset values: `in_ready=1`, `busy=0`, `satd_valid=0`, `satd_out=0`. State=IDLE, counters=0, `acc`=0. Buffer contents are don't-care.
- Rows may be back-to-back (one per cycle) or have gaps. Gaps in LOAD hold state indefinitely.
- Latency: if the 8th row is accepted at edge k, then:
  - COL occupies cycles k..k+7 (accumulations at edges k+1..k+8).
  - DONE occupies the cycle after edge k+8.
  - `satd_valid` is high for exactly that one cycle.
  - `in_ready` returns high at edge k+9.
- Throughput: one block per 17 cycles minimum (8 load + 8 column + 1 done).
- Asynchronous reset mid-operation clears everything immediately. No `satd_valid` is produced for the interrupted block.

## Configuration
- `SATD_NORM_EN`:
  - Defined: `satd_out` = (acc + 2) >> 2, matching encoder 8x8 SATD normalisation; result is zero-extended to SUM_W.
  - Undefined: `satd_out` = raw `acc`.
- Latency is identical in both cases.

## Test plan
- Reset then one block of all-zero diffs → `satd_valid` pulse after 9 edges; `satd_out=0` (both configurations).
- All 64 diffs = +1 → raw 64; with `SATD_NORM_EN`, 16.
- Single impulse at row 0, column 0 = +5, others 0 → raw 320; normalised 80.
- All diffs = −255, fed with `in_valid` gaps of 2 cycles between rows → raw 16320, normalised 4080; `in_ready=0` during COL/DONE; `in_valid` held high during COL is ignored.
- Checkerboard, diff(r,c) = +1 if r+c even else −1 → raw 64.
  - Then assert `clear` mid-block after 4 rows of a second block → no `satd_valid`; `satd_out` stays 64.
  - The next full block computes correctly.
- Assert `rst` low during COL → all outputs return to reset values at once; a subsequent all-zero block yields `satd_out=0`.

Source files
------------

// File: rtl/satd_hadamard_accum.sv
// 8x8 Hadamard SATD: row transform on entry, column transform + |coef| accumulation.
// Optional `SATD_NORM_EN selects (acc + 2) >> 2 normalisation of the result.
//   state | meaning
//   IDLE  | waiting for the first row of a block
//   LOAD  | rows 1..7 being collected into the transpose buffer
//   COL   | one column transformed and accumulated per cycle
//   DONE  | satd_out updated, satd_valid pulses
module satd_hadamard_accum #(
    parameter int DIFF_W = 9,
    parameter int SUM_W  = DIFF_W + 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIFF_W-1:0] diff_in_0,
    input  logic signed [DIFF_W-1:0] diff_in_1,
    input  logic signed [DIFF_W-1:0] diff_in_2,
    input  logic signed [DIFF_W-1:0] diff_in_3,
    input  logic signed [DIFF_W-1:0] diff_in_4,
    input  logic signed [DIFF_W-1:0] diff_in_5,
    input  logic signed [DIFF_W-1:0] diff_in_6,
    input  logic signed [DIFF_W-1:0] diff_in_7,
    output logic [SUM_W-1:0]         satd_out,
    output logic                     satd_valid,
    output logic                     busy
);

    localparam int RW = DIFF_W + 3;
    localparam int CW = DIFF_W + 6;
    localparam int AW = CW + 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic [2:0]         col_cnt_q, col_cnt_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [SUM_W-1:0]   satd_out_q, satd_out_d;
    logic [RW-1:0]      tbuf_q [8][8];

    logic signed [DIFF_W-1:0] din [8];
    logic [8*RW-1:0]    row_x, row_h;
    logic [8*CW-1:0]    col_x, col_h;
    logic [CW-1:0]      col_abs [8];
    logic [AW-1:0]      sum4 [4];
    logic [AW-1:0]      sum2 [2];
    logic [AW-1:0]      col_sum;
    logic [SUM_W-1:0]   acc_next;
    logic [SUM_W-1:0]   result;
    logic               row_we;

    function automatic logic [8*RW-1:0] had_row(input logic [8*RW-1:0] x);
        logic signed [RW-1:0] a [8];
        logic signed [RW-1:0] b [8];
        for (int i = 0; i < 8; i++) a[i] = x[i*RW +: RW];
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                if (((i >> s) % 2) == 0) b[i] = a[i] + a[i + (1 << s)];
                else                     b[i] = a[i - (1 << s)] - a[i];
            end
            for (int i = 0; i < 8; i++) a[i] = b[i];
        end
        for (int i = 0; i < 8; i++) had_row[i*RW +: RW] = a[i];
    endfunction

    function automatic logic [8*CW-1:0] had_col(input logic [8*CW-1:0] x);
        logic signed [CW-1:0] a [8];
        logic signed [CW-1:0] b [8];
        for (int i = 0; i < 8; i++) a[i] = x[i*CW +: CW];
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 8; i++) begin
                if (((i >> s) % 2) == 0) b[i] = a[i] + a[i + (1 << s)];
                else                     b[i] = a[i - (1 << s)] - a[i];
            end
            for (int i = 0; i < 8; i++) a[i] = b[i];
        end
        for (int i = 0; i < 8; i++) had_col[i*CW +: CW] = a[i];
    endfunction

    assign din[0] = diff_in_0;
    assign din[1] = diff_in_1;
    assign din[2] = diff_in_2;
    assign din[3] = diff_in_3;
    assign din[4] = diff_in_4;
    assign din[5] = diff_in_5;
    assign din[6] = diff_in_6;
    assign din[7] = diff_in_7;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        logic [CW-1:0] c;
        assign row_x[g*RW +: RW] = {{3{din[g][DIFF_W-1]}}, din[g]};
        assign col_x[g*CW +: CW] = {{3{tbuf_q[g][col_cnt_q][RW-1]}}, tbuf_q[g][col_cnt_q]};
        assign c                 = col_h[g*CW +: CW];
        // Magnitude fits CW bits unsigned even for the most negative coefficient.
        assign col_abs[g]        = c[CW-1] ? (~c + 1'b1) : c;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sum4
        assign sum4[g] = AW'(col_abs[2*g]) + AW'(col_abs[2*g+1]);
    end
    assign sum2[0] = sum4[0] + sum4[1];
    assign sum2[1] = sum4[2] + sum4[3];
    assign col_sum = sum2[0] + sum2[1];

    assign row_h    = had_row(row_x);
    assign col_h    = had_col(col_x);
    assign acc_next = acc_q + SUM_W'(col_sum);

`ifdef SATD_NORM_EN
    logic [SUM_W:0] acc_rnd;
    assign acc_rnd = {1'b0, acc_next} + (SUM_W+1)'(2);
    assign result  = SUM_W'(acc_rnd >> 2);
`else
    assign result  = acc_next;
`endif

    assign in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign busy       = (state_q == S_COL)  || (state_q == S_DONE);
    assign satd_valid = (state_q == S_DONE);
    assign satd_out   = satd_out_q;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        col_cnt_d  = col_cnt_q;
        acc_d      = acc_q;
        satd_out_d = satd_out_q;
        row_we     = 1'b0;
        if (clear) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
            col_cnt_d = '0;
            acc_d     = '0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (in_valid) begin
                        row_we    = 1'b1;
                        row_cnt_d = row_cnt_q + 3'd1;
                        if (row_cnt_q == 3'd7) begin
                            state_d   = S_COL;
                            col_cnt_d = '0;
                            acc_d     = '0;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
                S_COL: begin
                    acc_d     = acc_next;
                    col_cnt_d = col_cnt_q + 3'd1;
                    if (col_cnt_q == 3'd7) begin
                        state_d    = S_DONE;
                        satd_out_d = result;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            acc_q      <= '0;
            satd_out_q <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            col_cnt_q  <= col_cnt_d;
            acc_q      <= acc_d;
            satd_out_q <= satd_out_d;
        end
    end

    // Transpose buffer needs no reset: every row is rewritten before COL reads it.
    always_ff @(posedge clk) begin
        if (row_we) begin
            for (int i = 0; i < 8; i++) tbuf_q[row_cnt_q][i] <= row_h[i*RW +: RW];
        end
    end

endmodule
